// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM states, opcodes and the
// bundle of per-stage write enables and flush controls.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDUSE = 2'd1,
        MWAIT = 2'd2
    } hz_state_t;

    localparam logic [3:0] OPC_LW = 4'b0111;
    localparam logic [3:0] OPC_SW = 4'b1000;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEF = 8'b11111_000;
    localparam hz_ctrl_t CTRL_RST = 8'b00000_111;
    localparam hz_ctrl_t CTRL_MEM = 8'b00001_001;
    localparam hz_ctrl_t CTRL_BR  = 8'b11111_110;
    localparam hz_ctrl_t CTRL_LD  = 8'b00111_010;

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// Hazard-sequencer bundle: hazard sources from ID/EX/MEM in,
// per-stage controls and statistics out.
interface pipe_hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode_EX;
    logic             rs1_dep_EX;
    logic             rs2_dep_EX;
    logic             takeBr;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             memwb_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output opcode_EX, rs1_dep_EX, rs2_dep_EX,
        output takeBr, mem_req, mem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_flush, idex_flush, memwb_bubble,
        input  stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  opcode_EX, rs1_dep_EX, rs2_dep_EX,
        input  takeBr, mem_req, mem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_flush, idex_flush, memwb_bubble,
        output stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Hazard FSM driving every pipeline register: load-use stalls,
// branch flushes, data-memory waits, plus stall/flush statistics.
module pipe_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter logic [3:0] OPCODE_LW      = OPC_LW,
    parameter int         LOAD_STALL_CYC = 1,
    parameter int         MEM_TIMEOUT    = 8,
    parameter int         CNT_W          = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipe_hazard_sequencer_if.slave hz
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);
    localparam logic [1:0] LD_INIT = 2'(LOAD_STALL_CYC - 1);

    hz_state_t state_q, state_d, run_state;
    logic [1:0] ld_q, ld_d, run_ld;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic to_q, to_d;
    hz_ctrl_t ctrl, run_ctrl;
    logic lu, miss;

    assign lu   = (hz.opcode_EX == OPCODE_LW) &&
                  (hz.rs1_dep_EX || hz.rs2_dep_EX);
    assign miss = hz.mem_req && !hz.mem_ready;

    // Rules shared by RUN and the MWAIT release cycle
    always_comb begin
        run_ctrl  = CTRL_DEF;
        run_state = RUN;
        run_ld    = ld_q;
        if (hz.takeBr) begin
            run_ctrl = CTRL_BR;
        end else if (lu) begin
            run_ctrl = CTRL_LD;
            if (LOAD_STALL_CYC > 1) begin
                run_state = LDUSE;
                run_ld    = LD_INIT;
            end
        end
    end

    always_comb begin
        ctrl    = CTRL_DEF;
        state_d = state_q;
        ld_d    = ld_q;
        wcnt_d  = wcnt_q;
        to_d    = to_q;
        if (reset) begin
            ctrl    = CTRL_RST;
            state_d = RUN;
            ld_d    = '0;
            wcnt_d  = '0;
            to_d    = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (miss) begin
                        ctrl    = CTRL_MEM;
                        state_d = MWAIT;
                        wcnt_d  = WW'(1);
                    end else begin
                        ctrl    = run_ctrl;
                        state_d = run_state;
                        ld_d    = run_ld;
                    end
                end
                LDUSE: begin
                    if (miss) begin
                        ctrl    = CTRL_MEM;
                        state_d = MWAIT;
                        wcnt_d  = WW'(1);
                        ld_d    = '0;
                    end else begin
                        ctrl    = CTRL_LD;
                        ld_d    = ld_q - 2'd1;
                        state_d = (ld_q == 2'd1) ? RUN : LDUSE;
                    end
                end
                MWAIT: begin
                    if (!hz.mem_ready) begin
                        ctrl = CTRL_MEM;
                        if (wcnt_q != WMAX)
                            wcnt_d = wcnt_q + WW'(1);
                    end else begin
                        ctrl    = run_ctrl;
                        state_d = run_state;
                        ld_d    = run_ld;
                    end
                end
                default: state_d = RUN;
            endcase
            if (wcnt_d == WMAX)
                to_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ld_q    <= ld_d;
        wcnt_q  <= wcnt_d;
        to_q    <= to_d;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!ctrl.pc_we),
        .count (hz.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.ifid_flush),
        .count (hz.flush_cnt)
    );

    assign hz.pc_we        = ctrl.pc_we;
    assign hz.ifid_we      = ctrl.ifid_we;
    assign hz.idex_we      = ctrl.idex_we;
    assign hz.exmem_we     = ctrl.exmem_we;
    assign hz.memwb_we     = ctrl.memwb_we;
    assign hz.ifid_flush   = ctrl.ifid_flush;
    assign hz.idex_flush   = ctrl.idex_flush;
    assign hz.memwb_bubble = ctrl.memwb_bubble;
    assign hz.mem_timeout  = to_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Bench for pipe_hazard_sequencer: two configurations share one stimulus
// stream and are compared each cycle against an event-level model.
module tb_pipe_hazard_sequencer;

    logic       clk;
    logic [3:0] op;
    logic       r1, r2, br, mq, mr, rst;

    int checks = 0;
    int errors = 0;

    pipe_hazard_sequencer_if #(.CNT_W(16)) if1 ();
    pipe_hazard_sequencer_if #(.CNT_W(2))  if2 ();

    assign if1.opcode_EX  = op;
    assign if1.rs1_dep_EX = r1;
    assign if1.rs2_dep_EX = r2;
    assign if1.takeBr     = br;
    assign if1.mem_req    = mq;
    assign if1.mem_ready  = mr;
    assign if2.opcode_EX  = op;
    assign if2.rs1_dep_EX = r1;
    assign if2.rs2_dep_EX = r2;
    assign if2.takeBr     = br;
    assign if2.mem_req    = mq;
    assign if2.mem_ready  = mr;

    pipe_hazard_sequencer #(
        .OPCODE_LW(4'b0111), .LOAD_STALL_CYC(1),
        .MEM_TIMEOUT(8), .CNT_W(16)
    ) dut1 (
        .clk(clk), .reset(rst), .hz(if1.slave)
    );

    pipe_hazard_sequencer #(
        .OPCODE_LW(4'b0111), .LOAD_STALL_CYC(3),
        .MEM_TIMEOUT(8), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(rst), .hz(if2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k + 1, act, exp);
        end
    endtask

    // Model: remaining load-use cycles, wait length, saturating tallies
    int  lsc[2]    = '{1, 3};
    int  cmax[2]   = '{65535, 3};
    int  tmo       = 8;
    int  m_ld[2]   = '{0, 0};
    int  m_wl[2]   = '{0, 0};
    int  m_st[2]   = '{0, 0};
    int  m_fl[2]   = '{0, 0};
    bit  m_wait[2] = '{0, 0};
    bit  m_to[2]   = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0] en_a, en_e;
            logic [2:0] fl_a, fl_e;
            logic [31:0] st_a, fl_cnt_a;
            logic to_a;
            bit hold, lu;
            if (k == 0) begin
                en_a = {if1.pc_we, if1.ifid_we, if1.idex_we,
                        if1.exmem_we, if1.memwb_we};
                fl_a = {if1.ifid_flush, if1.idex_flush, if1.memwb_bubble};
                st_a = 32'(if1.stall_cnt);
                fl_cnt_a = 32'(if1.flush_cnt);
                to_a = if1.mem_timeout;
            end else begin
                en_a = {if2.pc_we, if2.ifid_we, if2.idex_we,
                        if2.exmem_we, if2.memwb_we};
                fl_a = {if2.ifid_flush, if2.idex_flush, if2.memwb_bubble};
                st_a = 32'(if2.stall_cnt);
                fl_cnt_a = 32'(if2.flush_cnt);
                to_a = if2.mem_timeout;
            end
            chk("stall_cnt", k, st_a, 32'(m_st[k]));
            chk("flush_cnt", k, fl_cnt_a, 32'(m_fl[k]));
            chk("mem_timeout", k, 32'(to_a), 32'(m_to[k]));
            en_e = 5'b11111;
            fl_e = 3'b000;
            if (rst) begin
                en_e = 5'b00000;
                fl_e = 3'b111;
                m_ld[k] = 0; m_wl[k] = 0; m_st[k] = 0;
                m_fl[k] = 0; m_wait[k] = 0; m_to[k] = 0;
            end else begin
                hold = m_wait[k] ? !mr : (mq && !mr);
                lu = (op == 4'b0111) && (r1 || r2);
                if (hold) begin
                    en_e = 5'b00001;
                    fl_e = 3'b001;
                    m_wl[k] = m_wait[k] ? ((m_wl[k] + 1 > tmo) ? tmo : m_wl[k] + 1) : 1;
                    m_wait[k] = 1;
                    m_ld[k] = 0;
                    if (m_wl[k] >= tmo) m_to[k] = 1;
                end else if (m_ld[k] > 0) begin
                    en_e = 5'b00111;
                    fl_e = 3'b010;
                    m_ld[k]--;
                end else begin
                    m_wait[k] = 0;
                    if (br) begin
                        fl_e = 3'b110;
                    end else if (lu) begin
                        en_e = 5'b00111;
                        fl_e = 3'b010;
                        m_ld[k] = lsc[k] - 1;
                    end
                end
                if (!en_e[4] && m_st[k] < cmax[k]) m_st[k]++;
                if (fl_e[2] && m_fl[k] < cmax[k]) m_fl[k]++;
            end
            chk("enables", k, 32'(en_a), 32'(en_e));
            chk("flushes", k, 32'(fl_a), 32'(fl_e));
        end
    end

    task automatic set(input logic [3:0] o, input logic a, input logic b,
                       input logic t, input logic q, input logic y,
                       input logic s);
        op = o; r1 = a; r2 = b; br = t; mq = q; mr = y; rst = s;
    endtask

    task automatic idle();
        set(4'h0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set(4'h0, 0, 0, 0, 0, 0, 1);
        tick();
        set(4'h0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("rst_pc_we", 0, 32'(if1.pc_we), 32'd0);
        chk("rst_flush", 0, 32'({if1.ifid_flush, if1.idex_flush, if1.memwb_bubble}), 32'h7);
        tick();
        idle();
        #1;
        chk("run_default", 0, 32'({if1.pc_we, if1.memwb_we, if1.ifid_flush}), 32'h6);
        chk("cnt_zero", 0, 32'(if1.stall_cnt), 32'd0);
        tick();

        // single-cycle load-use
        set(4'b0111, 0, 1, 0, 0, 0, 0);
        #1;
        chk("lu_ctrl", 0, 32'({if1.pc_we, if1.ifid_we, if1.idex_we, if1.idex_flush}), 32'h3);
        tick();
        idle();
        #1;
        chk("lu_done", 0, 32'(if1.pc_we), 32'd1);
        chk("lu_stall", 0, 32'(if1.stall_cnt), 32'd1);
        tick(); tick(); tick();

        // taken branch
        set(4'h0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("br_flush", 0, 32'({if1.ifid_flush, if1.idex_flush}), 32'h3);
        tick();
        idle();
        chk("br_fcnt", 0, 32'(if1.flush_cnt), 32'd1);
        chk("br_scnt", 0, 32'(if1.stall_cnt), 32'd1);
        tick();

        // memory wait with a branch held in EX
        set(4'h0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set(4'h0, 0, 0, 1, 1, 0, 0);
            #1;
            chk("mw_bubble", 0, 32'({if1.pc_we, if1.memwb_we, if1.memwb_bubble, if1.ifid_flush}), 32'h6);
            tick();
        end
        set(4'h0, 0, 0, 1, 1, 1, 0);
        #1;
        chk("mw_release", 0, 32'({if1.pc_we, if1.ifid_flush}), 32'h3);
        tick();
        idle();
        chk("mw_fcnt", 0, 32'(if1.flush_cnt), 32'd1);
        chk("mw_scnt", 0, 32'(if1.stall_cnt), 32'd4);
        chk("mw_no_to", 0, 32'(if1.mem_timeout), 32'd0);
        tick();

        // timeout
        for (int i = 1; i <= 10; i++) begin
            set(4'h0, 0, 0, 0, 1, 0, 0);
            tick();
            chk("to_edge", 0, 32'(if1.mem_timeout), 32'(i >= 8));
        end
        set(4'h0, 0, 0, 0, 1, 1, 0);
        tick();
        idle();
        tick(); tick();
        chk("to_sticky", 0, 32'(if1.mem_timeout), 32'd1);
        set(4'h0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("to_cleared", 0, 32'(if1.mem_timeout), 32'd0);

        // release straight into a load-use stall
        set(4'b0111, 1, 0, 0, 1, 0, 0);
        tick(); tick();
        set(4'b0111, 1, 0, 0, 1, 1, 0);
        #1;
        chk("rel_lu", 0, 32'({if1.pc_we, if1.idex_flush}), 32'h1);
        tick();
        idle();
        tick(); tick(); tick();

        // reset aborting a multi-cycle load-use stall
        set(4'h0, 0, 0, 0, 0, 0, 1);
        tick();
        set(4'b0111, 0, 1, 0, 0, 0, 0);
        tick();
        set(4'h0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("abort_rst", 1, 32'({if2.pc_we, if2.ifid_flush}), 32'h1);
        tick();
        idle();
        #1;
        chk("abort_run", 1, 32'(if2.pc_we), 32'd1);
        chk("abort_cnt", 1, 32'(if2.stall_cnt), 32'd0);
        tick();

        // saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            set(4'h0, 0, 0, 0, 1, 0, 0);
            tick();
        end
        set(4'h0, 0, 0, 0, 1, 1, 0);
        tick();
        idle();
        chk("sat_narrow", 1, 32'(if2.stall_cnt), 32'd3);
        chk("sat_wide", 0, 32'(if1.stall_cnt), 32'd5);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
